// File: rtl/adder_stream_pkg.sv
// Shared constants and types for the adder stream controller.
//   W_IN      operand width
//   W_SUM     sum width; the adder fixes this at W_IN+1 bits
//   operand_t one adder operand
//   sum_t     one adder result
package adder_stream_pkg;

    localparam int W_IN  = 16;
    localparam int W_SUM = W_IN + 1;

    typedef logic [W_IN-1:0]  operand_t;
    typedef logic [W_SUM-1:0] sum_t;

endpackage

// File: rtl/adder_stream_sum_fifo.sv
// sum_fifo: synchronous DEPTH-entry FIFO of sums with a registered head.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   push      write wdata this cycle
//   wdata     sum to write
//   pop       consume the head this cycle (ignored when empty)
//   head      registered head entry, stable until popped
//   valid     FIFO holds at least one entry (registered)
//   count     number of stored entries, 0..DEPTH
// The pointers carry one extra bit so that full and empty differ.
module sum_fifo
    import adder_stream_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W_SUM-1:0] wdata,
    input  logic          pop,
    output logic [W_SUM-1:0] head,
    output logic          valid,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    sum_t          mem [DEPTH];
    logic [AW:0]   wr_q, wr_d;
    logic [AW:0]   rd_q, rd_d;
    sum_t          head_q, head_d;
    logic          valid_q, valid_d;
    logic          full;
    logic          pop_eff;
    logic          push_eff;

    assign count    = wr_q - rd_q;
    assign full     = (count == FULL_CNT);
    assign pop_eff  = pop & valid_q;
    // A push into a full FIFO is only legal when a pop frees the slot.
    assign push_eff = push & (~full | pop_eff);

    always_comb begin
        wr_d    = wr_q + {{AW{1'b0}}, push_eff};
        rd_d    = rd_q + {{AW{1'b0}}, pop_eff};
        valid_d = (wr_d != rd_d);
        head_d  = head_q;
        // When the entry being written becomes the new head, take it
        // straight from wdata since mem is not updated until this edge.
        if (push_eff && (wr_q == rd_d)) begin
            head_d = wdata;
        end else if (valid_d) begin
            head_d = mem[rd_d[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem[wr_q[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            head_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            head_q  <= head_d;
            valid_q <= valid_d;
        end
    end

    assign head  = head_q;
    assign valid = valid_q;

endmodule

// File: rtl/adder_stream_ctrl.sv
// adder_stream_ctrl: stream front end for a fixed-latency 16-bit adder.
// Operand pairs accepted on the input stream are driven onto the adder,
// tracked through its latency by a valid-bit pipe, captured into a result
// FIFO and presented on the output stream in issue order. Issue is
// credit-limited so every issued pair is guaranteed a FIFO slot.
// Ports:
//   clk, rst          clock (shared with the adder), sync active-high reset
//   in_valid/in_ready input handshake; in_a/in_b operands
//   add_a/add_b       operands to the adder (zero unless a pair fires)
//   add_sum           adder result, ADDER_LAT cycles after sampling
//   out_valid/out_ready output handshake; out_sum registered FIFO head
// Optional build macro ADDER_STREAM_STATS_EN adds stat_issued/stat_done
// (32-bit counts of accepted pairs and consumed results).
module adder_stream_ctrl
    import adder_stream_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int ADDER_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_IN-1:0]  in_a,
    input  logic [W_IN-1:0]  in_b,
    output logic [W_IN-1:0]  add_a,
    output logic [W_IN-1:0]  add_b,
    input  logic [W_SUM-1:0] add_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_SUM-1:0] out_sum
`ifdef ADDER_STREAM_STATS_EN
    ,
    output logic [31:0]      stat_issued,
    output logic [31:0]      stat_done
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [ADDER_LAT-1:0] pipe_q, pipe_d;
    logic [AW:0]          fifo_count;
    logic                 fire;
    logic                 pop;
    logic                 push;
    int                   used;

    assign fire  = in_valid & in_ready;
    assign pop   = out_valid & out_ready;
    // The last pipe bit marks the cycle in which add_sum holds that pair.
    assign push  = pipe_q[ADDER_LAT-1];

    assign add_a = fire ? in_a : '0;
    assign add_b = fire ? in_b : '0;

    // Credits: pairs still in the adder plus stored sums must stay below
    // DEPTH. Uses registered state only, so a pop frees a credit one
    // cycle later.
    always_comb begin
        used = int'(fifo_count);
        for (int i = 0; i < ADDER_LAT; i++) begin
            used = used + int'(pipe_q[i]);
        end
        in_ready = ~rst & (used < DEPTH);
    end

    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = fire;
        for (int i = 1; i < ADDER_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    sum_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (add_sum),
        .pop   (pop),
        .head  (out_sum),
        .valid (out_valid),
        .count (fifo_count)
    );

`ifdef ADDER_STREAM_STATS_EN
    logic [31:0] stat_issued_q;
    logic [31:0] stat_done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued_q <= '0;
            stat_done_q   <= '0;
        end else begin
            if (fire) stat_issued_q <= stat_issued_q + 32'd1;
            if (pop)  stat_done_q   <= stat_done_q + 32'd1;
        end
    end

    assign stat_issued = stat_issued_q;
    assign stat_done   = stat_done_q;
`endif

endmodule
